// File: rtl/vga_timing_prog.sv
// Runtime-programmable VGA raster timing generator with a shadowed mode register
// set that is only applied at the frame boundary.
module vga_timing_prog #(
    parameter int unsigned W     = 12,
    parameter int unsigned H_VIS = 1024,
    parameter int unsigned H_SS  = 1032,
    parameter int unsigned H_SE  = 1176,
    parameter int unsigned H_TOT = 1344,
    parameter int unsigned V_VIS = 768,
    parameter int unsigned V_SS  = 771,
    parameter int unsigned V_SE  = 777,
    parameter int unsigned V_TOT = 806,
    parameter bit          H_POL = 1'b0,
    parameter bit          V_POL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_wr,
    input  logic [W-1:0] cfg_h_vis,
    input  logic [W-1:0] cfg_h_ss,
    input  logic [W-1:0] cfg_h_se,
    input  logic [W-1:0] cfg_h_tot,
    input  logic [W-1:0] cfg_v_vis,
    input  logic [W-1:0] cfg_v_ss,
    input  logic [W-1:0] cfg_v_se,
    input  logic [W-1:0] cfg_v_tot,
    input  logic         cfg_hpol,
    input  logic         cfg_vpol,
    output logic         cfg_pending,
    output logic         cfg_err,
    output logic [W-1:0] hdata,
    output logic [W-1:0] vdata,
    output logic         hsync,
    output logic         vsync,
    output logic         de,
    output logic         line_start,
    output logic         frame_start
);

    typedef struct packed {
        logic [W-1:0] hvis, hss, hse, htot;
        logic [W-1:0] vvis, vss, vse, vtot;
        logic         hpol, vpol;
    } mode_t;

    localparam logic [W-1:0] ONE = W'(1);
    localparam mode_t P_MODE = '{
        hvis: W'(H_VIS), hss: W'(H_SS), hse: W'(H_SE), htot: W'(H_TOT),
        vvis: W'(V_VIS), vss: W'(V_SS), vse: W'(V_SE), vtot: W'(V_TOT),
        hpol: H_POL, vpol: V_POL
    };

    mode_t        act, pend, cfg, act_nxt;
    logic [W-1:0] h_nxt, v_nxt;
    logic         started, wrap, cfg_ok;

    // hdata/vdata double as the raster counters; 'started' makes the first
    // edge after reset present (0,0) instead of advancing.
    always_comb begin
        cfg = '{
            hvis: cfg_h_vis, hss: cfg_h_ss, hse: cfg_h_se, htot: cfg_h_tot,
            vvis: cfg_v_vis, vss: cfg_v_ss, vse: cfg_v_se, vtot: cfg_v_tot,
            hpol: cfg_hpol, vpol: cfg_vpol
        };
        cfg_ok = (cfg.hvis != '0) && (cfg.hvis <= cfg.hss) && (cfg.hss < cfg.hse) &&
                 (cfg.hse <= cfg.htot) &&
                 (cfg.vvis != '0) && (cfg.vvis <= cfg.vss) && (cfg.vss < cfg.vse) &&
                 (cfg.vse <= cfg.vtot);

        wrap  = started && (hdata == act.htot - ONE) && (vdata == act.vtot - ONE);
        h_nxt = '0;
        v_nxt = '0;
        if (started) begin
            if (hdata == act.htot - ONE) begin
                v_nxt = (vdata == act.vtot - ONE) ? '0 : vdata + ONE;
            end else begin
                h_nxt = hdata + ONE;
                v_nxt = vdata;
            end
        end
        // Position (0,0) of a new frame is decoded with the incoming set
        act_nxt = (wrap && cfg_pending) ? pend : act;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act         <= P_MODE;
            pend        <= P_MODE;
            started     <= 1'b0;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
            hdata       <= '0;
            vdata       <= '0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            started     <= 1'b1;
            act         <= act_nxt;
            cfg_err     <= cfg_wr && !cfg_ok;
            if (cfg_wr && cfg_ok) begin
                pend        <= cfg;
                cfg_pending <= 1'b1;
            end else if (wrap) begin
                cfg_pending <= 1'b0;
            end
            hdata       <= h_nxt;
            vdata       <= v_nxt;
            de          <= (h_nxt < act_nxt.hvis) && (v_nxt < act_nxt.vvis);
            hsync       <= ((h_nxt >= act_nxt.hss) && (h_nxt < act_nxt.hse)) ?
                           act_nxt.hpol : ~act_nxt.hpol;
            vsync       <= ((v_nxt >= act_nxt.vss) && (v_nxt < act_nxt.vse)) ?
                           act_nxt.vpol : ~act_nxt.vpol;
            line_start  <= (h_nxt == '0);
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

endmodule

// File: doc/vga_timing_prog.md
# vga_timing_prog

Runtime-programmable VGA raster timing generator. It is the parametrised successor to the fixed-mode timing cores. The power-up mode comes from parameters. A new mode (visible area, porches, sync widths, sync polarities) can be loaded at any time and takes effect only at the next frame boundary, so the output never produces a torn frame. It sits between the pixel clock domain and the pixel fetch/DVI encoder, and drives position, sync and display-enable.

## Interface
- `W`, 12: width of all counters, position outputs and cfg timing fields.
- `H_VIS`, 1024: visible pixels per line.
- `H_SS`, 1032: hsync start (first sync pixel).
- `H_SE`, 1176: hsync end (first pixel after sync).
- `H_TOT`, 1344: total pixels per line.
- `V_VIS`, 768: visible lines.
- `V_SS`, 771: vsync start line.
- `V_SE`, 777: vsync end line.
- `V_TOT`, 806: total lines.
- `H_POL`, 0: hsync active level (0 = active-low).
- `V_POL`, 0: vsync active level (0 = active-low).

Ports:
- `clk` in 1: pixel clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `cfg_wr` in 1: one-cycle strobe that captures all `cfg_*` inputs.
- `cfg_h_vis`, `cfg_h_ss`, `cfg_h_se`, `cfg_h_tot` in W each: horizontal timing.
- `cfg_v_vis`, `cfg_v_ss`, `cfg_v_se`, `cfg_v_tot` in W each: vertical timing.
- `cfg_hpol`, `cfg_vpol` in 1 each: sync polarities.
- `cfg_pending` out 1: a validated mode is waiting for the frame boundary.
- `cfg_err` out 1: one-cycle pulse when a `cfg_wr` is rejected.
- `hdata` out W: current pixel column, 0..h_tot-1.
- `vdata` out W: current line, 0..v_tot-1.
- `hsync` out 1: horizontal sync, at the programmed polarity.
- `vsync` out 1: vertical sync, at the programmed polarity.
- `de` out 1: display enable.
- `line_start` out 1: high while `hdata`==0.
- `frame_start` out 1: high while `hdata`==0 and `vdata`==0.

## Operation
- There are three register sets:
  - **Active**: the set currently used for counting and decode.
  - **Pending**: the shadow that holds the next mode.
  - **Output registers.**
- Reset loads the parameter values into the active set.
- Horizontal counter `h` increments every clock. When `h`==h_tot-1 it wraps to 0 and `v` increments. When `v`==v_tot-1 at the same time, `v` also wraps to 0.
- Decode uses the active set:
  - `de` = (h<h_vis) and (v<v_vis).
  - hsync is active when h_ss<=h<h_se.
  - vsync is active when v_ss<=v<v_se, for the whole line, changing at h=0.
  - The active level of each sync equals its pol bit.
- `hdata` and `vdata` carry the raw counter values during blanking as well as the visible area.
- Validation on `cfg_wr`:
  - A write is accepted only if 1<=vis<=ss<se<=tot, checked separately for H and for V, using unsigned W-bit compare.
  - Accepted: the fields are copied into pending and `cfg_pending` is set to 1. A later accepted write overwrites the earlier one (last write wins).
  - Rejected: pending and `cfg_pending` are unchanged, and `cfg_err` pulses high for one cycle.
- Apply: on the edge where the counters wrap from (h_tot-1, v_tot-1) to (0,0) with `cfg_pending`=1:
  - Active is loaded from pending and `cfg_pending` clears.
  - Position (0,0) of the new frame is already decoded with the new set.
- Simultaneous `cfg_wr` on the apply edge:
  - The previous pending value is applied.
  - The new write is validated and becomes pending (`cfg_pending` stays 1) for the following frame.
- If no mode is pending at the wrap, the active set is unchanged.

## Timing
- All outputs are registered and mutually aligned. Latency from counter state to pins is 1 clock.
- Reset values while `rst_n`=0:
  - `hdata`=0, `vdata`=0, `de`=0, `line_start`=0, `frame_start`=0, `cfg_pending`=0, `cfg_err`=0.
  - `hsync`=~H_POL and `vsync`=~V_POL (inactive levels).
- First rising edge after release: outputs present (0,0), so `de`=1, `line_start`=1, `frame_start`=1.
- Outputs on edge k after release present raster position k-1.
- `cfg_err` is asserted on the edge following the rejected `cfg_wr`. `cfg_pending` rises on the edge following an accepted `cfg_wr`.
- Asserting reset mid-frame immediately forces the reset values and discards both the pending mode and any previously applied runtime mode; after release the generator restarts at (0,0) in the parameter mode.
- Counters never exceed tot-1. Arithmetic is W-bit unsigned with no saturation.

## Test plan
- **Reset:** hold `rst_n`=0 for 5 clocks → all outputs at their reset values, `hsync`=`vsync`=1. On the first edge after release → `frame_start`=1, `de`=1, `hdata`=0, `vdata`=0.
- **Default mode:**
  - hsync is low exactly for `hdata` 1032..1175 (144 clocks) and the line period is 1344 clocks.
  - vsync is low for lines 771..776.
  - `frame_start` recurs every 1083264 clocks and `de` is high for 786432 clocks per frame.
- **Runtime switch:** mid-frame, write 640/656/752/800, 480/490/492/525, pol 0/0 → `cfg_pending`=1.
  - The old timing continues until (1343,805).
  - The next frame has 800-clock lines, 525 lines, and hsync low for `hdata` 656..751.
  - `cfg_pending` clears at the apply edge.
- **Reject:** write with h_ss=h_se → `cfg_err` pulses for 1 clock, `cfg_pending` is unchanged and timing is unchanged.
- **Boundary write:** with a small mode 4/5/6/8, 2/3/4/5 pending, strobe `cfg_wr` with 6/6/7/9 … on the apply edge → the small mode is applied, `cfg_pending` stays 1, and the second mode applies one frame later.
- **Mid-frame reset:** at (500,300) after a runtime switch, pulse `rst_n` low → the pending mode is discarded, the parameter mode is restored and the raster restarts at (0,0).
